// File: rtl/pcm_arbiter_if.sv
// Requester-side and PCM-side signal bundle for pcm_arbiter.
// slave = the arbiter; master = requesters plus the PCM driving the arbiter's inputs.
interface pcm_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SIG_W   = 256
);
    // Requester side
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*3-1:0]     req_instr;
    logic [NUM_REQ*32-1:0]    req_id;
    logic [NUM_REQ*SIG_W-1:0] req_sig;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_ok;
    logic                     rsp_comp;
    logic [31:0]              rsp_status;
    logic [31:0]              rsp_data;
    logic                     busy;

    // PCM side
    logic [2:0]               pcm_instr;
    logic [31:0]              pcm_id;
    logic [SIG_W-1:0]         pcm_sig;
    logic                     pcm_sig_valid;
    logic [31:0]              pcm_status;
    logic                     pcm_comp;
    logic [31:0]              pcm_ctrl;

    modport slave (
        input  req, req_instr, req_id, req_sig,
        input  pcm_status, pcm_comp, pcm_ctrl,
        output rsp_valid, rsp_ok, rsp_comp, rsp_status, rsp_data, busy,
        output pcm_instr, pcm_id, pcm_sig, pcm_sig_valid
    );

    modport master (
        output req, req_instr, req_id, req_sig,
        output pcm_status, pcm_comp, pcm_ctrl,
        input  rsp_valid, rsp_ok, rsp_comp, rsp_status, rsp_data, busy,
        input  pcm_instr, pcm_id, pcm_sig, pcm_sig_valid
    );
endinterface

// File: rtl/pcm_arbiter.sv
// Arbiter/sequencer sharing one PUF comparison manager (PCM) between NUM_REQ requesters.
// Round-robin by default; define PCM_ARB_FIXED_PRIO_EN for lowest-index-first priority.
module pcm_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          SIG_W          = 256,
    parameter int          PCM_LAT        = 1,
    parameter logic [31:0] ILLEGAL_STATUS = 32'd5
) (
    input  logic         clk,
    input  logic         rst,
    pcm_arbiter_if.slave bus
);

    localparam int         IDX_W      = $clog2(NUM_REQ);
    localparam int         SUM_W      = IDX_W + 1;
    localparam logic [2:0] OP_IDLE    = 3'd0;
    localparam logic [2:0] OP_COMPARE = 3'd2;
    localparam logic [2:0] OP_MAX     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // Winner selection
    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] win_idx;
    logic [SUM_W-1:0] cand;
    logic             win_found;
    logic [2:0]       win_instr;
    logic [31:0]      win_id;
    logic [SIG_W-1:0] win_sig;
    logic             win_legal;
    logic             grant;

    // Latched transaction
    logic [IDX_W-1:0] grant_idx;
    logic [2:0]       instr_q;
    logic [31:0]      id_q;
    logic [SIG_W-1:0] sig_q;
    logic [3:0]       wait_cnt;
    logic             wait_done;

    // Response registers
    logic             rsp_ok_q;
    logic             rsp_comp_q;
    logic [31:0]      rsp_status_q;
    logic [31:0]      rsp_data_q;

`ifdef PCM_ARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    // rr_ptr holds the first index to search next, i.e. last_grant+1 wrapped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    assign search_start = rr_ptr;
`endif

    // NOTE: every variable assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = SUM_W'(search_start) + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!win_found && bus.req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_instr = 3'(bus.req_instr >> (32'(win_idx) * 3));
    assign win_id    = 32'(bus.req_id >> (32'(win_idx) * 32));
    assign win_sig   = SIG_W'(bus.req_sig >> (32'(win_idx) * SIG_W));
    assign win_legal = (win_instr != OP_IDLE) && (win_instr <= OP_MAX);
    assign grant     = (state == S_IDLE) && win_found;
    assign wait_done = (state == S_WAIT) && (wait_cnt == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = win_legal ? S_CLEAR : S_RESP;
                end
            end
            S_CLEAR: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The latched signature is reset as well, because pcm_sig must read zero out
    // of reset; the cost is a reset on every bit of this wide register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_idx    <= '0;
            instr_q      <= OP_IDLE;
            id_q         <= '0;
            sig_q        <= '0;
            wait_cnt     <= '0;
            rsp_ok_q     <= 1'b0;
            rsp_comp_q   <= 1'b0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            if (grant) begin
                grant_idx <= win_idx;
                instr_q   <= win_instr;
                id_q      <= win_id;
                sig_q     <= win_sig;
                if (!win_legal) begin
                    rsp_ok_q     <= 1'b0;
                    rsp_comp_q   <= 1'b0;
                    rsp_status_q <= ILLEGAL_STATUS;
                    rsp_data_q   <= '0;
                end
            end

            if (state == S_ISSUE) begin
                wait_cnt <= 4'(PCM_LAT - 1);
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // PCM outputs are valid on the final WAIT cycle.
            if (wait_done) begin
                rsp_ok_q     <= (bus.pcm_status == 32'd0);
                rsp_comp_q   <= bus.pcm_comp;
                rsp_status_q <= bus.pcm_status;
                rsp_data_q   <= bus.pcm_ctrl;
            end
        end
    end

    // Outside ISSUE the PCM sees IDLE_IN, which also clears any stale status.
    always_comb begin
        bus.pcm_instr     = OP_IDLE;
        bus.pcm_sig_valid = 1'b0;
        bus.rsp_valid     = '0;
        case (state)
            S_ISSUE: begin
                bus.pcm_instr     = instr_q;
                bus.pcm_sig_valid = (instr_q == OP_COMPARE);
            end
            S_RESP: begin
                bus.rsp_valid = NUM_REQ'(1) << grant_idx;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.pcm_id     = id_q;
    assign bus.pcm_sig    = sig_q;
    assign bus.rsp_ok     = rsp_ok_q;
    assign bus.rsp_comp   = rsp_comp_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.rsp_data   = rsp_data_q;

endmodule

// File: doc/pcm_arbiter.md
# pcm_arbiter

Round-robin arbiter and sequencer that shares a single PUF comparison manager (PCM) instance between `NUM_REQ` requesting IPs. It sits directly in front of the PCM and owns its `Instruction_in`, `IP_ID_in`, `sig_in` and `sig_valid` inputs. It serialises requests, clears stale PCM status before every command, and samples the PCM outputs after a fixed latency. Results go back to the granted requester as a one-cycle response.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `SIG_W`, 256: PUF signature width; matches PCM `puf_sig_length`.
- `PCM_LAT`, 1: cycles from the PCM capturing an instruction to its outputs being valid (1..15).
- `ILLEGAL_STATUS`, 32'd5: status code returned for rejected opcodes.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `req` in NUM_REQ: per-requester request level.
- `req_instr` in NUM_REQ*3: opcode for requester k in bits [3k+2:3k].
- `req_id` in NUM_REQ*32: IP ID for requester k.
- `req_sig` in NUM_REQ*SIG_W: signature for requester k.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle response strobe.
- `rsp_ok` out 1: command succeeded (PCM status == 0).
- `rsp_comp` out 1: PCM `comp_out`; meaningful for COMPARE only.
- `rsp_status` out 32: sampled PCM status.
- `rsp_data` out 32: sampled PCM `control_out`; meaningful for GEN_CHNG only.
- `busy` out 1: high in every state except IDLE.
- `pcm_instr` out 3: to PCM `Instruction_in`.
- `pcm_id` out 32: to PCM `IP_ID_in`.
- `pcm_sig` out SIG_W: to PCM `sig_in`.
- `pcm_sig_valid` out 1: to PCM `sig_valid`.
- `pcm_status` in 32, `pcm_comp` in 1, `pcm_ctrl` in 32: from the PCM.

## Operation
- FSM states and transitions: IDLE -> CLEAR -> ISSUE -> WAIT -> RESP -> IDLE. An illegal opcode goes IDLE -> RESP directly.
- **IDLE:** if any `req` bit is high, the arbiter picks a winner and latches its index, opcode, ID and signature into internal registers. The requester's inputs may change freely after the grant cycle.
- **Arbitration:** round-robin. The search starts at `(last_grant+1) mod NUM_REQ`; the pointer resets to 0. `last_grant` updates on every grant, including illegal-opcode grants.
- **Opcode legality:** legal opcodes are 1..5 (GEN_CHNG, COMPARE, PROV_ID, PROV_EXP, STR_CHNG). Opcodes 0, 6 and 7 are illegal and produce a response with `rsp_ok`=0, `rsp_status`=`ILLEGAL_STATUS`, `rsp_comp`=0 and `rsp_data`=0. The PCM is not touched.
- **CLEAR:** drives `pcm_instr`=0 (IDLE_IN) for one cycle, which forces the PCM status to 0.
- **ISSUE:** drives the latched opcode, ID and signature for one cycle. `pcm_sig_valid`=1 only when the opcode is COMPARE.
- **WAIT:** `pcm_instr`=0 and a down-counter runs `PCM_LAT` cycles. On the final WAIT cycle the block captures:
  - `rsp_status` <= `pcm_status`
  - `rsp_ok` <= (`pcm_status`==0)
  - `rsp_comp` <= `pcm_comp`
  - `rsp_data` <= `pcm_ctrl`
- **RESP:** `rsp_valid[grant]`=1 for exactly one cycle. The `rsp_*` values hold until the next RESP.
- **Request protocol:** the requester must drop `req` by the clock edge that ends its `rsp_valid` cycle; otherwise it is served again as a new transaction.
- **Idle drive:** outside ISSUE, `pcm_instr`=0 and `pcm_sig_valid`=0. `pcm_id` and `pcm_sig` continuously show the latched values.

## Timing
- Reset values:
  - state = IDLE, RR pointer = 0.
  - `rsp_valid`=0, `rsp_ok`=0, `rsp_comp`=0, `rsp_status`=0, `rsp_data`=0, `busy`=0.
  - `pcm_instr`=0, `pcm_id`=0, `pcm_sig`=0, `pcm_sig_valid`=0.
- Legal command with grant in cycle t:
  - CLEAR at t+1, ISSUE at t+2, WAIT from t+3 to t+2+PCM_LAT.
  - `rsp_valid` at t+3+PCM_LAT.
  - Next grant is possible at t+4+PCM_LAT.
- Illegal command with grant in cycle t: `rsp_valid` at t+1.
- Simultaneous requests: one grant per IDLE cycle; losers wait. No requester is skipped for more than NUM_REQ-1 grants.
- Reset in any state forces IDLE on the next edge. An in-flight response is dropped and no `rsp_valid` is issued. The PCM is assumed reset by the same `rst`.

## Configuration
- `PCM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest asserted index wins, and the RR pointer is removed.
  - Undefined (default): round-robin as specified above.
  - All other behaviour is identical in both builds.

## Test plan
- **Single requester:** req[0], instr=3 (PROV_ID), id=0xA5 with PCM_LAT=1.
  - `pcm_instr`=3 exactly at t+2.
  - `rsp_valid`=4'b0001 at t+4 with `rsp_ok`=1 and `rsp_status`=0.
- **Repeat PROV_ID:** issue PROV_ID id=0xA5 a second time.
  - `rsp_ok`=0 and `rsp_status`=3 (IP_PRESENT).
  - Then a COMPARE on an unknown id=0x77 returns `rsp_status`=2 and `rsp_ok`=0.
- **Round-robin fairness:** `req`=4'b1111 held and re-asserted after each response.
  - Grant order is 0,1,2,3,0.
  - With `PCM_ARB_FIXED_PRIO_EN` defined, requester 0 wins every time.
- **Full flow:** PROV_ID, PROV_EXP with sig S, then COMPARE with sig S.
  - The COMPARE returns `rsp_comp`=1 and `pcm_sig_valid` is high only during ISSUE.
  - A COMPARE with S^1 (single-bit error) still returns `rsp_comp`=1.
- **Illegal opcode:** req[2] with instr=7.
  - `rsp_valid`=4'b0100 one cycle after the grant, `rsp_status`=5.
  - `pcm_instr` stays 0 throughout.
- **Reset mid-operation:** assert `rst`=0 during WAIT.
  - Next cycle `busy`=0 and no `rsp_valid` appears.
  - After release, a new request is served starting from requester 0.
